// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO: default widths/depth and the
// capture-FSM state encoding.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } cap_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side handshake between a UART receiver (master) and the FIFO (slave).
interface uart_rx_fifo_if #(
    parameter int DATA_W = uart_pkg::DATA_W
);
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready_clr;

    modport master (
        output rx_ready,
        output rx_data,
        input  rx_ready_clr
    );

    modport slave (
        input  rx_ready,
        input  rx_data,
        output rx_ready_clr
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. Occupancy is tracked in its own counter so
// full and empty never rely on comparing pointers.
module uart_sync_fifo #(
    parameter int DEPTH  = uart_pkg::FIFO_DEPTH,
    parameter int DATA_W = uart_pkg::DATA_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);
    import uart_pkg::*;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              pop_s;
    logic              push_s;

    // A pop needs data present; a push is allowed when full only if a pop
    // frees a slot in the same cycle.
    always_comb begin
        pop_s  = rd_en && !empty_q;
        push_s = wr_en && (!full_q || pop_s);
    end

    // Next pointer, occupancy and flag values; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == CW'(0));
        full_d  = (count_d == CW'(DEPTH));
    end

    // Pointer, occupancy and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each byte offered by the receiver exactly once,
// acknowledges it with a one-cycle pulse, and queues it for the consumer.
// Bytes arriving while full with no pop in the same cycle are dropped and
// flagged in a sticky overflow bit.
module uart_rx_fifo #(
    parameter int DEPTH  = uart_pkg::FIFO_DEPTH,
    parameter int DATA_W = uart_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_rx_fifo_if.slave          rx_if,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    import uart_pkg::*;

    cap_state_e state_q, state_d;
    logic       clr_q, clr_d;
    logic       ovf_q, ovf_d;
    logic       wr_attempt_s;
    logic       pop_s;
    logic       drop_s;

    // Write is attempted only from IDLE; a drop is a full FIFO with no pop.
    always_comb begin
        wr_attempt_s = (state_q == IDLE) && rx_if.rx_ready;
        pop_s        = rd_en && !empty;
        drop_s       = wr_attempt_s && full && !pop_s;
    end

    // Capture FSM next state; the acknowledge pulse is issued on entry to ACK.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_if.rx_ready) begin
                    state_d = ACK;
                    clr_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!rx_if.rx_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_comb begin
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FSM state, acknowledge pulse and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ovf_q   <= ovf_d;
        end
    end

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_attempt_s),
        .wr_data (rx_if.rx_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign rx_if.rx_ready_clr = clr_q;
    assign overflow           = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes into a
// queue, a negedge monitor compares every effective pop against it and tracks
// acknowledge pulses.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic          ovf_clr;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic          overflow;
    logic [4:0]    count;

    uart_rx_fifo_if #(.DATA_W(DW)) rx_if ();

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_if    (rx_if),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          clr_pulses = 0;
    int          clr_cycles = 0;
    logic        clr_prev = 1'b0;
    logic [7:0]  exp_q [$];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pulse accounting and pop-data comparison against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rx_if.rx_ready_clr) begin
                clr_cycles++;
                if (!clr_prev) clr_pulses++;
            end
            clr_prev = rx_if.rx_ready_clr;
            if (rd_en && !empty) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no data at %0t", rd_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", int'(rd_data), int'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        rx_if.rx_data  = b;
        rx_if.rx_ready = 1'b1;
        tick(hold);
        rx_if.rx_ready = 1'b0;
        tick(2);
    endtask

    task automatic pop(input int n);
        rd_en = 1'b1;
        tick(n);
        rd_en = 1'b0;
        tick(1);
    endtask

    initial begin
        int p0;
        int c0;
        rst            = 1'b1;
        rd_en          = 1'b0;
        ovf_clr        = 1'b0;
        rx_if.rx_ready = 1'b0;
        rx_if.rx_data  = 8'h00;
        tick(3);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_clr", int'(rx_if.rx_ready_clr), 0);
        rst = 1'b0;
        tick(1);

        // Three bytes, no pops.
        p0 = clr_pulses; c0 = clr_cycles;
        exp_q.push_back(8'h41); send(8'h41, 3);
        exp_q.push_back(8'h55); send(8'h55, 3);
        exp_q.push_back(8'hAA); send(8'hAA, 3);
        check("three_count", int'(count), 3);
        check("three_pulses", clr_pulses - p0, 3);
        check("three_clr_cycles", clr_cycles - c0, 3);
        pop(3);
        check("three_empty", int'(empty), 1);

        // Long rx_ready hold produces one capture.
        p0 = clr_pulses; c0 = clr_cycles;
        exp_q.push_back(8'h41); send(8'h41, 20);
        check("hold_pulses", clr_pulses - p0, 1);
        check("hold_clr_cycles", clr_cycles - c0, 1);
        check("hold_count", int'(count), 1);
        pop(1);

        // Fill, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'(i));
            send(8'(i), 3);
        end
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 16);
        check("fill_no_ovf", int'(overflow), 0);
        p0 = clr_pulses;
        send(8'hFF, 3);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_count", int'(count), 16);
        check("ovf_pulse", clr_pulses - p0, 1);
        pop(DEPTH);
        check("ovf_drain_empty", int'(empty), 1);
        check("ovf_sticky", int'(overflow), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(overflow), 0);

        // Full FIFO with simultaneous capture and pop.
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            send(8'(8'h10 + i), 3);
        end
        exp_q.push_back(8'h77);
        rx_if.rx_data  = 8'h77;
        rx_if.rx_ready = 1'b1;
        rd_en          = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(2);
        rx_if.rx_ready = 1'b0;
        tick(2);
        check("simul_count", int'(count), 16);
        check("simul_full", int'(full), 1);
        check("simul_no_ovf", int'(overflow), 0);
        pop(DEPTH);
        check("simul_drain_empty", int'(empty), 1);

        // Pops while empty are ignored.
        rd_en = 1'b1;
        tick(3);
        rd_en = 1'b0;
        tick(1);
        check("empty_pop_count", int'(count), 0);
        check("empty_pop_empty", int'(empty), 1);
        exp_q.push_back(8'h5A); send(8'h5A, 3);
        check("after_empty_pop_count", int'(count), 1);
        pop(1);

        // Reset in ACK with five bytes stored.
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h61 + i), 3);
        end
        check("pre_rst_count", int'(count), 5);
        rx_if.rx_data  = 8'h66;
        rx_if.rx_ready = 1'b1;
        tick(1);
        check("pre_rst_ack", int'(rx_if.rx_ready_clr), 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_full", int'(full), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        check("mid_rst_clr", int'(rx_if.rx_ready_clr), 0);
        p0 = clr_pulses;
        exp_q.push_back(8'h66);
        rst = 1'b0;
        tick(4);
        rx_if.rx_ready = 1'b0;
        tick(2);
        check("post_rst_count", int'(count), 1);
        check("post_rst_pulses", clr_pulses - p0, 1);
        pop(1);
        check("final_empty", int'(empty), 1);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter DATA_W, default 8, bits per received byte.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge on clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_ready  input  1  level from the UART receiver: a received byte is held on rx_data.
REQ-006 rx_data  input  DATA_W  received byte, stable while rx_ready is high.
REQ-007 rx_ready_clr  output  1  one-cycle pulse to the UART receiver acknowledging the byte.
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 rd_data  output  DATA_W  head entry (show-ahead); valid whenever empty is low.
REQ-010 empty  output  1  count == 0.
REQ-011 full  output  1  count == DEPTH.
REQ-012 count  output  log2(DEPTH)+1  current occupancy.
REQ-013 overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-014 ovf_clr  input  1  clears overflow.

Function
REQ-015 Capture FSM SHALL have states IDLE, ACK and WAIT_LOW.
- IDLE: when rx_ready=1 in cycle N, the FSM SHALL write rx_data at the end of cycle N (or drop it, see REQ-018) and go to ACK.
- ACK: rx_ready_clr SHALL be 1 for exactly cycle N+1; the FSM then goes to WAIT_LOW.
- WAIT_LOW: the FSM SHALL stay until rx_ready=0, then return to IDLE; no capture occurs in ACK or WAIT_LOW.
REQ-016 Each rx_ready assertion SHALL cause exactly one write attempt and exactly one rx_ready_clr pulse.
REQ-017 rx_ready_clr SHALL be 0 in every state other than ACK.
REQ-018 Write with full=1 and no simultaneous effective pop: the byte SHALL be dropped, overflow set next cycle, and rx_ready_clr still pulsed.
REQ-019 An effective pop is rd_en=1 with empty=0; rd_en with empty=1 SHALL be ignored, with no pointer or count change.
REQ-020 Simultaneous write and effective pop, including when full: both SHALL occur, and count SHALL be unchanged.
REQ-021 Write latency: a byte captured in cycle N SHALL appear in count/empty in cycle N+1; if the FIFO was empty it SHALL be on rd_data in cycle N+1.
REQ-022 Pop: rd_data SHALL present the next entry in the cycle after the pop.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL be maintained separately, with no pointer-compare ambiguity at full.
REQ-024 Data SHALL be returned in arrival order, bit-exact.
REQ-025 If ovf_clr and a new overflow event occur in the same cycle, overflow SHALL remain 1 (set wins).

Reset
REQ-026 Synchronous reset SHALL set: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, rx_ready_clr=0.
REQ-027 Reset mid-operation SHALL discard all stored bytes and any pending acknowledge; a byte still held high on rx_ready after reset release SHALL be captured once.
REQ-028 Memory contents need not be reset; rd_data is don't-care while empty=1.

Structure
REQ-029 Shared package uart_pkg SHALL hold DATA_W, the default FIFO depth, and the capture-FSM state enum.
REQ-030 Storage, pointers and count SHALL live in the sub-module uart_sync_fifo; uart_rx_fifo adds the capture FSM and overflow logic.

Verification
REQ-031 Receiver delivers 0x41, 0x55, 0xAA with rd_en=0 -> count=3, three single-cycle rx_ready_clr pulses, pops return 0x41, 0x55, 0xAA, then empty=1.
REQ-032 rx_ready held high 20 cycles for 0x41 -> exactly one write and one rx_ready_clr pulse; count=1.
REQ-033 Fill 16 bytes 0x00..0x0F, then send 0xFF -> full=1, overflow=1, 0xFF dropped, rx_ready_clr pulsed; pops return 0x00..0x0F.
REQ-034 Full FIFO, rd_en=1 in the same cycle as capture of 0x77 -> count stays 16, 0x77 is the last entry popped, overflow=0.
REQ-035 rd_en=1 while empty -> count=0, no state change; ovf_clr clears overflow.
REQ-036 Reset asserted with 5 bytes stored during ACK -> all outputs at REQ-026 values next cycle.
